// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives datapath strobes per state.
module multicycle_control #(
  parameter int CNT_W       = 16,
  parameter bit ADDI_EN     = 1'b1,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t cur_state;
  state_t nxt_state;
  ctrl_t  ctrl;
  logic   done_raw;
  logic   go_trap;
  logic   illegal_q;
  logic   ready;

  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state   <= S_FETCH;
      retired_cnt <= '0;
      illegal_q   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (done_raw)
        retired_cnt <= retired_cnt + CNT_W'(1);
      if (go_trap)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    ctrl      = '0;
    done_raw  = 1'b0;
    go_trap   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        if (ready)
          nxt_state = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        case (opcode)
          6'd0:        nxt_state = S_EXEC;
          6'd35, 6'd43: nxt_state = S_MEMADR;
          6'd4:        nxt_state = S_BRANCH;
          6'd2:        nxt_state = S_JUMP;
          6'd8: begin
            if (ADDI_EN) begin
              nxt_state = S_ADDIEX;
            end else begin
              nxt_state = S_TRAP;
              go_trap   = 1'b1;
            end
          end
          default: begin
            nxt_state = S_TRAP;
            go_trap   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        nxt_state      = (opcode == 6'd35) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (ready)
          nxt_state = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        done_raw        = 1'b1;
        nxt_state       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (ready) begin
          done_raw  = 1'b1;
          nxt_state = S_FETCH;
        end
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        nxt_state      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        done_raw       = 1'b1;
        nxt_state      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        done_raw           = 1'b1;
        nxt_state          = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
        done_raw       = 1'b1;
        nxt_state      = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        nxt_state      = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        done_raw       = 1'b1;
        nxt_state      = S_FETCH;
      end
      default: begin
        // TRAP and the unused codes 13-15 all park here until reset
        go_trap   = 1'b1;
        nxt_state = cur_state;
      end
    endcase
  end

  // Everything except the debug state and sticky flag is forced quiet in reset
  assign PCWrite     = rst_n & ctrl.pc_write;
  assign PCWriteCond = rst_n & ctrl.pc_write_cond;
  assign IorD        = rst_n & ctrl.iord;
  assign MemRead     = rst_n & ctrl.mem_read;
  assign MemWrite    = rst_n & ctrl.mem_write;
  assign IRWrite     = rst_n & ctrl.ir_write;
  assign MemtoReg    = rst_n & ctrl.mem_to_reg;
  assign RegDst      = rst_n & ctrl.reg_dst;
  assign RegWrite    = rst_n & ctrl.reg_write;
  assign ALUSrcA     = rst_n & ctrl.alu_src_a;
  assign ALUSrcB     = rst_n ? ctrl.alu_src_b : 2'b00;
  assign ALUOp       = rst_n ? ctrl.alu_op : 2'b00;
  assign PCSource    = rst_n ? ctrl.pc_source : 2'b00;
  assign instr_done  = rst_n & done_raw;
  assign state       = cur_state;
  assign illegal_op  = illegal_q;

endmodule
